// File: rtl/gpu_ucode_sequencer_pkg.sv
// Shared micro-op encodings for the GPU microcode sequencer: word size,
// opcode/operand field bounds and the flow-control opcode values.
package gpu_ucode_sequencer_pkg;

  localparam int GPU_UOP_SZ  = 32;
  localparam int GPU_OP_HI   = 31;
  localparam int GPU_OP_LO   = 26;
  localparam int GPU_OPND_HI = 17;
  localparam int GPU_OPND_LO = 0;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_WRL  = 6'd1,
    OP_GOTO = 6'd2,
    OP_JZ   = 6'd3,
    OP_JNZ  = 6'd4,
    OP_CALL = 6'd5,
    OP_RET  = 6'd6,
    OP_HALT = 6'd7
  } uop_op_e;

  function automatic uop_op_e uop_opcode(input logic [GPU_UOP_SZ-1:0] u);
    return uop_op_e'(u[GPU_OP_HI:GPU_OP_LO]);
  endfunction

endpackage

// File: rtl/gpu_ucode_stack.sv
// Return-address LIFO for the microcode sequencer. The caller never pushes
// when full nor pops when empty; flush empties it in one cycle.
module gpu_ucode_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-2:0] top_idx;

  // DEPTH is a power of two, so the low count bits wrap to the top entry.
  assign top_idx = count[CW-2:0] - 1'b1;
  assign dout    = mem[top_idx];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (push) begin
      count <= count + 1'b1;
    end else if (pop) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[count[CW-2:0]] <= din;
    end
  end

endmodule

// File: rtl/gpu_ucode_sequencer.sv
// GPU microcode sequencer: loadable program RAM, registered micro-op output,
// zero-bubble flow control, halt/restart. Call/return via GPU_USEQ_CALL_STACK_EN.
module gpu_ucode_sequencer
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                UOP_W       = GPU_UOP_SZ,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter string             INIT_FILE   = ""
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStall,
  input  logic              iZero,
  input  logic              iRestart,
  input  logic              iLoadEn,
  input  logic [ADDR_W-1:0] iLoadAddr,
  input  logic [UOP_W-1:0]  iLoadData,
  output logic [UOP_W-1:0]  oUop,
  output logic [ADDR_W-1:0] oPC,
  output logic              oHalted,
  output logic              oStackErr
);

  localparam int DEPTH = 1 << ADDR_W;

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_stack
    $error("STACK_DEPTH must be a power of two >= 2");
  end

  logic [UOP_W-1:0]  ram [DEPTH];
  logic [UOP_W-1:0]  uop;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic              halted;
  logic              halt_now;
  logic              load_we;
  uop_op_e           opcode;
  logic              unused_uop;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  end

  assign opcode     = uop_opcode(uop[GPU_UOP_SZ-1:0]);
  assign target     = uop[GPU_OPND_LO +: ADDR_W];
  assign pc_inc     = pc + 1'b1;
  assign unused_uop = ^uop;

`ifdef GPU_USEQ_CALL_STACK_EN
  logic              push;
  logic              pop;
  logic              err_set;
  logic              stk_full;
  logic              stk_empty;
  logic              stack_err;
  logic [ADDR_W-1:0] ret_addr;

  gpu_ucode_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (iClock),
    .rst   (iReset),
    .flush (halted && iRestart),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stack_err <= 1'b0;
    end else if (err_set) begin
      stack_err <= 1'b1;
    end
  end

  assign oStackErr = stack_err;
`else
  assign oStackErr = 1'b0;
`endif

  // Next fetch address; flow ops only act when the sequencer actually advances.
  always_comb begin
    next_pc  = pc_inc;
    halt_now = 1'b0;
`ifdef GPU_USEQ_CALL_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
`endif
    if (halted || iStall) begin
      next_pc = pc;
    end else begin
      case (opcode)
        OP_GOTO: next_pc = target;
        OP_JZ:   if (iZero)  next_pc = target;
        OP_JNZ:  if (!iZero) next_pc = target;
`ifdef GPU_USEQ_CALL_STACK_EN
        OP_CALL: begin
          next_pc = target;
          if (stk_full) err_set = 1'b1;
          else          push    = 1'b1;
        end
        OP_RET: begin
          if (stk_empty) begin
            err_set  = 1'b1;
            halt_now = 1'b1;
            next_pc  = pc;
          end else begin
            pop     = 1'b1;
            next_pc = ret_addr;
          end
        end
`endif
        OP_HALT: begin
          halt_now = 1'b1;
          next_pc  = pc;
        end
        default: ;
      endcase
    end
  end

  // Halted is the only control state; gnop is presented for its whole duration.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      pc     <= RESET_PC;
      uop    <= '0;
      halted <= 1'b0;
    end else if (halted) begin
      if (iRestart) begin
        pc     <= RESET_PC;
        uop    <= '0;
        halted <= 1'b0;
      end
    end else if (!iStall) begin
      pc     <= next_pc;
      uop    <= halt_now ? '0 : ram[next_pc];
      halted <= halt_now;
    end
  end

  // Read-first: the fetch above samples the RAM before this write lands.
  assign load_we = iLoadEn && halted && !iReset;

  always_ff @(posedge iClock) begin
    if (load_we) begin
      ram[iLoadAddr] <= iLoadData;
    end
  end

  assign oUop    = uop;
  assign oPC     = pc;
  assign oHalted = halted;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Bench for gpu_ucode_sequencer: directed programs plus random programs,
// checked cycle by cycle against a reference model through a scoreboard.
module tb_gpu_ucode_sequencer;
  import gpu_ucode_sequencer_pkg::*;

  localparam int RP = 0;
`ifdef GPU_USEQ_CALL_STACK_EN
  localparam int STACK_DEPTH = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        zero;
  logic        restart;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] uop_out;
  logic [7:0]  pc_out;
  logic        halted_out;
  logic        err_out;

  gpu_ucode_sequencer dut (
    .iClock    (clk),
    .iReset    (rst),
    .iStall    (stall),
    .iZero     (zero),
    .iRestart  (restart),
    .iLoadEn   (load_en),
    .iLoadAddr (load_addr),
    .iLoadData (load_data),
    .oUop      (uop_out),
    .oPC       (pc_out),
    .oHalted   (halted_out),
    .oStackErr (err_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mem [256];
  int          m_pc;
  logic [31:0] m_uop;
  bit          m_halt;
  bit          m_err;
  int          stk[$];

  logic [41:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [17:0] opnd);
    return {op, 8'h00, opnd};
  endfunction

  task automatic model_step(input bit r, input bit rs, input bit st, input bit z,
                            input bit le, input logic [7:0] la, input logic [31:0] ld);
    int npc;
    int tgt;
    bit hlt;
    if (r) begin
      m_pc = RP; m_uop = '0; m_halt = 0; m_err = 0; stk.delete();
      return;
    end
    if (m_halt) begin
      if (le) mem[la] = ld;
      if (rs) begin
        m_pc = RP; m_uop = '0; m_halt = 0; stk.delete();
      end
      return;
    end
    if (st) return;
    tgt = int'(m_uop[7:0]);
    npc = (m_pc + 1) % 256;
    hlt = 0;
    case (m_uop[31:26])
      OP_GOTO: npc = tgt;
      OP_JZ:   if (z) npc = tgt;
      OP_JNZ:  if (!z) npc = tgt;
`ifdef GPU_USEQ_CALL_STACK_EN
      OP_CALL: begin
        if (stk.size() < STACK_DEPTH) stk.push_back((m_pc + 1) % 256);
        else m_err = 1;
        npc = tgt;
      end
      OP_RET: begin
        if (stk.size() == 0) begin m_err = 1; hlt = 1; end
        else npc = stk.pop_back();
      end
`endif
      OP_HALT: hlt = 1;
      default: ;
    endcase
    if (hlt) begin
      m_halt = 1;
      m_uop  = '0;
    end else begin
      m_pc  = npc;
      m_uop = mem[npc];
    end
  endtask

  // driver: called at a falling edge, returns at the next one
  task automatic cycle(input bit r, input bit rs, input bit st, input bit z,
                       input bit le, input logic [7:0] la, input logic [31:0] ld);
    rst = r; restart = rs; stall = st; zero = z;
    load_en = le; load_addr = la; load_data = ld;
    model_step(r, rs, st, z, le, la, ld);
    exp_q.push_back({m_err, m_halt, 8'(m_pc), m_uop});
    @(negedge clk);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    cycle(0, 0, 0, 0, 1, a, d);
  endtask

  task automatic clear_region(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) load_word(8'(a), 32'h0);
  endtask

  task automatic do_restart();
    cycle(0, 1, 0, 0, 0, 8'h0, 32'h0);
  endtask

  task automatic run(input int budget, input int stall_pct, input bit zero_rand,
                     input int zero_n, input bit chaos);
    int c = 0;
    while (c < budget && halted_out !== 1'b1) begin
      cycle(chaos && ($urandom_range(0, 99) < 2),
            chaos && ($urandom_range(0, 99) < 5),
            $urandom_range(0, 99) < stall_pct,
            zero_rand ? 1'($urandom_range(0, 1)) : (c < zero_n),
            chaos && ($urandom_range(0, 99) < 10),
            8'($urandom), $urandom);
      c++;
    end
    n_checks++;
    if (halted_out === 1'b1) n_pass++;
    else $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted_out, c);
  endtask

  function automatic logic [31:0] rand_uop(input int a);
    int          r  = $urandom_range(0, 9);
    int          t  = $urandom_range(a + 1, 48);
    logic [17:0] op = {10'($urandom), 8'(t)};
    case (r)
      0, 1:    return {6'(OP_WRL), 26'($urandom)};
      2:       return {6'($urandom_range(8, 63)), 26'($urandom)};
      3:       return mk(OP_GOTO, op);
      4:       return mk(OP_JZ, op);
      5:       return mk(OP_JNZ, op);
      6:       return mk(OP_CALL, op);
      7:       return mk(OP_RET, op);
      8:       return mk(OP_HALT, op);
      default: return 32'h0;
    endcase
  endfunction

  // monitor: one output word per clock, compared against the scoreboard
  always @(posedge clk) begin
    logic [41:0] exp;
    logic [41:0] got;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {err_out, halted_out, pc_out, uop_out};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_check t=%0t: got err=%b halt=%b pc=%0d uop=%h, required err=%b halt=%b pc=%0d uop=%h",
                    $time, got[41], got[40], got[39:32], got[31:0],
                    exp[41], exp[40], exp[39:32], exp[31:0]);
    end
  end

  initial begin
    rst = 1; stall = 0; zero = 0; restart = 0; load_en = 0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = mk(OP_HALT, 18'h0);
    m_pc = RP; m_uop = '0; m_halt = 0; m_err = 0;
    #1 dut.ram[1] = mk(OP_HALT, 18'h0);
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 8'h0, 32'h0);
    cycle(1, 1, 1, 0, 1, 8'h5, 32'h1);
    run(20, 0, 0, 0, 0);

    // tight loop 0,1,2,1,2 while zero holds, then fall through to halt
    load_word(8'd1, mk(OP_WRL, 18'h2abcd));
    load_word(8'd2, mk(OP_JZ, 18'h1));
    load_word(8'd3, mk(OP_HALT, 18'h0));
    do_restart();
    run(40, 0, 0, 8, 0);

    // conditional jumps with both zero polarities; upper operand bits ignored
    clear_region(1, 2);
    load_word(8'd3, mk(OP_JZ, 18'h3fc05));
    load_word(8'd4, mk(OP_JNZ, 18'h6));
    load_word(8'd5, mk(OP_JNZ, 18'h7));
    load_word(8'd6, mk(OP_HALT, 18'h0));
    load_word(8'd7, mk(OP_HALT, 18'h0));
    do_restart();
    run(40, 0, 0, 40, 0);
    do_restart();
    run(40, 0, 0, 0, 0);

    // straight-line code under heavy stalling
    for (int a = 1; a <= 12; a++) load_word(8'(a), {6'(OP_WRL), 26'($urandom)});
    load_word(8'd13, mk(OP_HALT, 18'h0));
    do_restart();
    run(200, 50, 1, 0, 0);

    // nested calls: overflow on the fifth, then return chain ending on empty
    clear_region(1, 63);
    load_word(8'd1,  mk(OP_CALL, 18'd10));
    load_word(8'd2,  mk(OP_RET, 18'd0));
    load_word(8'd3,  mk(OP_HALT, 18'd0));
    load_word(8'd10, mk(OP_CALL, 18'd20));
    load_word(8'd11, mk(OP_RET, 18'd0));
    load_word(8'd20, mk(OP_CALL, 18'd30));
    load_word(8'd21, mk(OP_RET, 18'd0));
    load_word(8'd30, mk(OP_CALL, 18'd40));
    load_word(8'd31, mk(OP_RET, 18'd0));
    load_word(8'd40, mk(OP_CALL, 18'd50));
    load_word(8'd50, mk(OP_RET, 18'd0));
    do_restart();
    run(200, 20, 1, 0, 0);

    // address wrap 255 -> 0
    clear_region(1, 63);
    load_word(8'd1,   mk(OP_JZ, 18'd254));
    load_word(8'd2,   mk(OP_HALT, 18'd0));
    load_word(8'd254, mk(OP_WRL, 18'h11));
    load_word(8'd255, mk(OP_WRL, 18'h22));
    do_restart();
    run(40, 0, 0, 3, 0);

    // random programs with random stall/zero, stray restarts, loads and resets
    for (int p = 0; p < 6; p++) begin
      load_word(8'd0, 32'h0);
      for (int a = 1; a <= 47; a++) load_word(8'(a), rand_uop(a));
      load_word(8'd48, mk(OP_HALT, 18'($urandom)));
      clear_region(49, 63);
      do_restart();
      run(600, 25, 1, 0, 1);
    end

    // restart into a self loop; loads while running must be ignored
    load_word(8'd1, mk(OP_GOTO, 18'd1));
    do_restart();
    for (int i = 0; i < 6; i++) cycle(0, i == 3, 0, 0, 1, 8'd1, mk(OP_HALT, 18'd0));

    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
